seg7_capture: RTL and testbench

Scanned seven-segment capture block: samples an active-low segment bus and active-low digit-select lines, such as a multiplexed display drive, and recovers the hex value and decimal point shown on each digit. Each display pattern must be held stable for a configurable number of clocks before it is captured. The block is the inverse of the team's hex-to-segment decoder, which maps value to active-low segments with bit 7 as the decimal point. It lets self-test logic and benches read back what a display is showing.

---
 rtl/seg7_capture.sv | 154 +++++++++++++++
 tb/tb_seg7_capture.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Recovers hex value and decimal point per digit from a scanned active-low seven-segment drive.
// Optional input synchronizer: define SEG7_CAPTURE_SYNC_EN.
module seg7_capture #(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [7:0]        nHEX,
  input  logic [NDIG-1:0]   nDIGSEL,
  output logic [4*NDIG-1:0] DOUT,
  output logic [NDIG-1:0]   DOT,
  output logic [NDIG-1:0]   VALID,
  output logic              UPD,
  output logic [2:0]        UPD_IDX,
  output logic              ERR
);

  localparam int SW = 8 + NDIG;
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  smp_in, samp_q, prev_q;
  logic           legal, cap, hit;
  logic [3:0]     val;
  logic [2:0]     idx;
  logic [NDIG-1:0] sel_oh;

`ifdef SEG7_CAPTURE_SYNC_EN
  logic [SW-1:0] sync1_q, sync2_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {nHEX, nDIGSEL};
      sync2_q <= sync1_q;
    end
  end

  assign smp_in = sync2_q;
`else
  assign smp_in = {nHEX, nDIGSEL};
`endif

  // prev_q is the previous sample; a run continues only while samp_q equals it
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      samp_q  <= '1;
      prev_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      samp_q  <= smp_in;
      prev_q  <= samp_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel_oh = ~samp_q[NDIG-1:0];

  always_comb begin
    int n;
    n   = 0;
    idx = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (sel_oh[i]) begin
        n   = n + 1;
        idx = 3'(i);
      end
    end
    legal = (n == 1);
  end

  always_comb begin
    hit = 1'b1;
    val = 4'h0;
    case (samp_q[NDIG+6:NDIG])
      7'h40: val = 4'h0;
      7'h79: val = 4'h1;
      7'h24: val = 4'h2;
      7'h30: val = 4'h3;
      7'h19: val = 4'h4;
      7'h12: val = 4'h5;
      7'h02: val = 4'h6;
      7'h78: val = 4'h7;
      7'h00: val = 4'h8;
      7'h10: val = 4'h9;
      7'h08: val = 4'hA;
      7'h03: val = 4'hB;
      7'h46: val = 4'hC;
      7'h21: val = 4'hD;
      7'h06: val = 4'hE;
      7'h0E: val = 4'hF;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    if (!legal) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if ((samp_q != prev_q) || (state_q == IDLE)) begin
      cnt_d = ONE_C;
      if (STABLE_C == ONE_C) begin
        cap     = 1'b1;
        state_d = HELD;
      end else begin
        state_d = TRACK;
      end
    end else if (state_q == TRACK) begin
      cnt_d = cnt_q + ONE_C;
      if (cnt_d == STABLE_C) begin
        cap     = 1'b1;
        state_d = HELD;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      DOUT    <= '0;
      DOT     <= '0;
      VALID   <= '0;
      UPD     <= 1'b0;
      ERR     <= 1'b0;
      UPD_IDX <= 3'd0;
    end else begin
      UPD <= cap & hit;
      ERR <= cap & ~hit;
      if (cap) UPD_IDX <= idx;
      for (int i = 0; i < NDIG; i++) begin
        if (cap && sel_oh[i]) begin
          VALID[i] <= hit;
          if (hit) begin
            DOUT[4*i +: 4] <= val;
            DOT[i]         <= ~samp_q[NDIG+7];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture (NDIG=4, STABLE=4, no input synchronizer).
module tb_seg7_capture;

  localparam int NDIG   = 4;
  localparam int STABLE = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [7:0]  nHEX = 8'hFF;
  logic [3:0]  nDIGSEL = 4'hF;
  logic [15:0] DOUT;
  logic [3:0]  DOT, VALID;
  logic        UPD, ERR;
  logic [2:0]  UPD_IDX;

  seg7_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .CLK(CLK), .nRST(nRST), .nHEX(nHEX), .nDIGSEL(nDIGSEL),
    .DOUT(DOUT), .DOT(DOT), .VALID(VALID),
    .UPD(UPD), .UPD_IDX(UPD_IDX), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          err;
    int          idx;
    logic [15:0] dout;
    logic [3:0]  dot;
    logic [3:0]  valid;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  logic [7:0]  codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [15:0] sh_dout = '0;
  logic [3:0]  sh_dot = '0;
  logic [3:0]  sh_valid = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (nRST) begin
      if (UPD || ERR) begin
        if (sb.size() == 0) begin
          check_val("unexpected_pulse", {30'd0, UPD, ERR}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("pulse_kind", {30'd0, UPD, ERR}, e.err ? 32'd1 : 32'd2);
          check_val("upd_idx", 32'(UPD_IDX), 32'(e.idx));
          check_val("dout", 32'(DOUT), 32'(e.dout));
          check_val("dot", 32'(DOT), 32'(e.dot));
          check_val("valid", 32'(VALID), 32'(e.valid));
          check_val("latency", 32'(cyc), 32'(e.at));
        end
      end else if (sb.size() > 0 && cyc >= sb[0].at) begin
        check_val("missed_pulse", 32'(cyc), 32'(sb[0].at + 1));
        void'(sb.pop_front());
      end
    end
  end

  // Drive a pattern for n edges starting right after a negedge.
  task automatic apply(input logic [7:0] hex, input logic [3:0] sel, input int n);
    int   d, lows;
    bit   hit;
    int   v;
    exp_t e;
    nHEX    = hex;
    nDIGSEL = sel;
    lows = 0;
    d    = 0;
    for (int i = 0; i < 4; i++) if (!sel[i]) begin lows++; d = i; end
    if (lows == 1 && n >= STABLE) begin
      hit = 0;
      v   = 0;
      for (int c = 0; c < 16; c++) if (codes[c][6:0] == hex[6:0]) begin hit = 1; v = c; end
      if (hit) begin
        sh_dout[4*d +: 4] = 4'(v);
        sh_dot[d]         = ~hex[7];
      end
      sh_valid[d] = hit;
      e.err   = !hit;
      e.idx   = d;
      e.dout  = sh_dout;
      e.dot   = sh_dot;
      e.valid = sh_valid;
      e.at    = cyc + 1 + STABLE;
      sb.push_back(e);
    end
    repeat (n) @(negedge CLK);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge CLK);
    check_val("queue_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_val("rst_dout", 32'(DOUT), 32'd0);
    check_val("rst_flags", {23'd0, UPD, ERR, UPD_IDX, VALID}, 32'd0);
    check_val("rst_dot", 32'(DOT), 32'd0);
    nRST = 1'b1;

    apply(8'hC0, 4'b1110, 6);
    apply(8'h10, 4'b1011, 6);
    apply(8'hB0, 4'b1101, 3);
    apply(8'hA4, 4'b1101, 4);
    apply(8'hFF, 4'b1111, 1);
    apply(8'hA4, 4'b1101, 5);
    apply(8'h80, 4'b0111, 6);
    apply(8'hFF, 4'b0111, 6);
    apply(8'h00, 4'b1100, 10);
    apply(8'h80, 4'b1111, 10);
    apply(8'h92, 4'b1110, 3);
    apply(8'h12, 4'b1110, 5);
    apply(8'h12, 4'b1011, 2);
    apply(8'h12, 4'b1110, 4);
    drain();

    for (int it = 0; it < 30; it++) begin
      int d, v, n;
      logic [7:0] h;
      d = $urandom_range(0, 3);
      v = $urandom_range(0, 15);
      n = $urandom_range(1, 7);
      h = codes[v];
      h[7] = $urandom_range(0, 1) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 4) == 0) h = 8'($urandom_range(0, 255));
      apply(h, ~(4'b0001 << d), n);
      apply(8'hFF, 4'b1111, 1);
    end
    drain();

    apply(8'hC0, 4'b1110, 2);
    nRST = 1'b0;
    #1;
    check_val("midrst_dout", 32'(DOUT), 32'd0);
    check_val("midrst_flags", {23'd0, UPD, ERR, UPD_IDX, VALID}, 32'd0);
    check_val("midrst_dot", 32'(DOT), 32'd0);
    sh_dout  = '0;
    sh_dot   = '0;
    sh_valid = '0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    apply(8'hC0, 4'b1110, 8);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
